// File: rtl/accel_wb_pkg.sv
// Shared types for the accelerator Wishbone master.
//   WB_AW / WB_DW : Wishbone address / data widths (32).
//   state_e       : bus-side FSM states.
//   cmd_t         : queued command {we, addr, wdata}, 65 bits.
package accel_wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] wdata;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/accel_cmd_fifo.sv
// Synchronous command FIFO.
//   clk, reset       : clock, async active-high reset (empties the queue)
//   push_i/push_data_i, full_o  : write side
//   pop_i/pop_data_o, empty_o   : read side, pop_data_o shows the head
// A push while full is taken only when a pop happens in the same cycle,
// in which case the count stays unchanged.
module accel_cmd_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 65
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(FIFO_DEPTH));
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];

  // Depth is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/accel_wb_master.sv
// Command-queue driven Wishbone classic master for the accelerator.
//   cmd_*        : command input (valid/ready), queued in accel_cmd_fifo
//   rsp_*        : one response per command, in command order
//   wishbone_*   : single classic bus cycles, stb == cyc
//   busy         : queue non-empty or a command still in flight
// Optional macro ACCEL_WB_MASTER_TIMEOUT_EN adds a bus-cycle timeout of
// TIMEOUT_CYCLES clocks that terminates the cycle with an error.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no command in flight; pops the FIFO head when available
// REQ     | cyc/stb asserted, waiting for ack/err (or timeout)
// RESP    | rsp_valid held until rsp_ready
module accel_wb_master
  import accel_wb_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [WB_AW-1:0] cmd_addr,
  input  logic [WB_DW-1:0] cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WB_DW-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             wishbone_cyc_o,
  output logic             wishbone_stb_o,
  output logic             wishbone_we_o,
  output logic [WB_AW-1:0] wishbone_addr_o,
  output logic [WB_DW-1:0] wishbone_data_o,
  input  logic [WB_DW-1:0] wishbone_data_i,
  input  logic             wishbone_ack_i,
  input  logic             wishbone_err_i,
  output logic             busy
);

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [WB_AW-1:0] addr_q, addr_d;
  logic [WB_DW-1:0] data_q, data_d;
  logic [WB_DW-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [CMD_W-1:0] fifo_rdata;
  cmd_t             head;
  logic             timeout_hit;

  accel_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (CMD_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (cmd_valid && cmd_ready),
    .push_data_i ({cmd_we, cmd_addr, cmd_wdata}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign head = cmd_t'(fifo_rdata);

`ifdef ACCEL_WB_MASTER_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;

  // Zero outside REQ, so every bus cycle starts counting from 0.
  assign to_cnt_d    = (state_q == ST_REQ) ? to_cnt_q + 16'd1 : 16'd0;
  assign timeout_hit = (state_q == ST_REQ) && (to_cnt_d == TO_LIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  logic [15:0] unused_to_lim;
  assign unused_to_lim = TO_LIM;
  assign timeout_hit   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cyc_d    = 1'b1;
          we_d     = head.we;
          addr_d   = head.addr;
          data_d   = head.wdata;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        // err beats ack; a real termination beats a timeout in the same cycle
        if (wishbone_err_i || (!wishbone_ack_i && timeout_hit)) begin
          cyc_d   = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (wishbone_ack_i) begin
          cyc_d   = 1'b0;
          rdata_d = we_q ? '0 : wishbone_data_i;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready       = !fifo_full;
  assign rsp_valid       = (state_q == ST_RESP);
  assign rsp_rdata       = rdata_q;
  assign rsp_err         = err_q;
  assign wishbone_cyc_o  = cyc_q;
  assign wishbone_stb_o  = cyc_q;
  assign wishbone_we_o   = we_q;
  assign wishbone_addr_o = addr_q;
  assign wishbone_data_o = data_q;
  assign busy            = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_accel_wb_master.sv
module tb_accel_wb_master;

  localparam int DEPTH  = 4;
  localparam int TO_CYC = 8;
  localparam int N_RAND = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        wishbone_cyc_o, wishbone_stb_o, wishbone_we_o;
  logic [31:0] wishbone_addr_o, wishbone_data_o, wishbone_data_i;
  logic        wishbone_ack_i, wishbone_err_i;
  logic        busy;

  accel_wb_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wishbone_cyc_o(wishbone_cyc_o), .wishbone_stb_o(wishbone_stb_o),
    .wishbone_we_o(wishbone_we_o), .wishbone_addr_o(wishbone_addr_o),
    .wishbone_data_o(wishbone_data_o), .wishbone_data_i(wishbone_data_i),
    .wishbone_ack_i(wishbone_ack_i), .wishbone_err_i(wishbone_err_i),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } tcmd_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        ack;
    logic        err;
    logic [31:0] sdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } tv_t;

  tcmd_t exp_q[$];
  int    rsp_seen;

  // slave behaviour controls
  bit          rand_mode = 1'b0;
  bit          sl_stall = 1'b0;
  bit          force_ack = 1'b0;
  int          sl_lat = 0;
  bit          sl_ack = 1'b1;
  bit          sl_err = 1'b0;
  logic [31:0] sl_data = '0;

  // In random mode the slave's reaction is a pure function of the address:
  // latency = addr[1:0], err = addr[4], ack suppressed when addr[5:4]==2'b11.
  function automatic logic [31:0] slave_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin : slave
    int wcnt;
    int lat;
    bit a, e;
    logic [31:0] d;
    wcnt = 0;
    wishbone_ack_i = 1'b0;
    wishbone_err_i = 1'b0;
    wishbone_data_i = '0;
    forever begin
      @(posedge clk); #1;
      wishbone_ack_i = 1'b0;
      wishbone_err_i = 1'b0;
      if (wishbone_cyc_o && wishbone_stb_o && !sl_stall) begin
        if (rand_mode) begin
          lat = int'(wishbone_addr_o[1:0]);
          a = !(wishbone_addr_o[5] && wishbone_addr_o[4]);
          e = wishbone_addr_o[4];
          d = slave_word(wishbone_addr_o);
        end else begin
          lat = sl_lat; a = sl_ack; e = sl_err; d = sl_data;
        end
        if (wcnt == lat) begin
          wishbone_ack_i = a;
          wishbone_err_i = e;
          wishbone_data_i = d;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
        if (force_ack) begin
          wishbone_ack_i = 1'b1;
          wishbone_data_i = 32'hBAD0_BAD0;
        end else if (rand_mode && !wishbone_cyc_o) begin
          wishbone_ack_i = 1'($urandom % 2);
          wishbone_err_i = 1'($urandom % 2);
          wishbone_data_i = $urandom;
        end
      end
    end
  end

  // One clock of the random/queue flow: check the bus against the oldest
  // outstanding command, check/consume a response, offer a command.
  task automatic run_cycle(input bit offer, input bit take, input tcmd_t c);
    tcmd_t h;
    logic  e_err;
    if (wishbone_cyc_o) begin
      chk("bus_outstanding", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        chk("bus_addr", wishbone_addr_o, h.addr);
        chk("bus_we", 32'(wishbone_we_o), 32'(h.we));
        chk("bus_data", wishbone_data_o, h.wdata);
      end
    end
    rsp_ready = take;
    if (rsp_valid && rsp_ready) begin
      chk("rsp_outstanding", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        h = exp_q.pop_front();
        e_err = h.addr[4];
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        chk("rsp_rdata", rsp_rdata, (h.we || e_err) ? 32'd0 : slave_word(h.addr));
        rsp_seen++;
      end
    end
    cmd_valid = offer;
    cmd_we = c.we;
    cmd_addr = c.addr;
    cmd_wdata = c.wdata;
    if (cmd_valid && cmd_ready) exp_q.push_back(c);
    @(posedge clk); #1;
  endtask

  // Directed single transaction on an otherwise idle master.
  task automatic do_txn(input tv_t t, input int exp_stb);
    int n;
    int bad;
    sl_lat = t.lat; sl_ack = t.ack; sl_err = t.err; sl_data = t.sdata;
    cmd_we = t.we; cmd_addr = t.addr; cmd_wdata = t.wdata;
    cmd_valid = 1'b1;
    chk("txn_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("txn_gap_cyc", 32'(wishbone_cyc_o), 32'd0);
    chk("txn_gap_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    n = 0; bad = 0;
    while (wishbone_cyc_o && n < 40) begin
      n++;
      if (!wishbone_stb_o || wishbone_we_o !== t.we || wishbone_addr_o !== t.addr ||
          wishbone_data_o !== t.wdata) bad++;
      @(posedge clk); #1;
    end
    chk("txn_stb_cycles", 32'(n), 32'(exp_stb));
    chk("txn_bus_hold", 32'(bad), 32'd0);
    chk("txn_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("txn_rsp_rdata", rsp_rdata, t.exp_rdata);
    chk("txn_rsp_err", 32'(rsp_err), 32'(t.exp_err));
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("txn_done_valid", 32'(rsp_valid), 32'd0);
    chk("txn_done_busy", 32'(busy), 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    tv_t   tv[6];
    tcmd_t c;
    int    sent, cyc_cnt, bad, n;
    bit    off;

    tv[0] = '{1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 2, 1'b1, 1'b0, 32'h1111_1111, 32'h0, 1'b0};
    tv[1] = '{1'b0, 32'h2000_0000, 32'h0,         0, 1'b1, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0};
    tv[2] = '{1'b0, 32'h3000_0004, 32'h0,         1, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b1};
    tv[3] = '{1'b1, 32'h4000_0008, 32'h0000_0001, 0, 1'b0, 1'b1, 32'h5555_5555, 32'h0, 1'b1};
    tv[4] = '{1'b0, 32'hF000_000C, 32'h0,         3, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    tv[5] = '{1'b0, 32'h5000_0000, 32'h0,         0, 1'b0, 1'b1, 32'h8765_4321, 32'h0, 1'b1};

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_cyc", 32'(wishbone_cyc_o), 32'd0);
    chk("rst_stb", 32'(wishbone_stb_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_wb_addr", wishbone_addr_o, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // directed table
    for (int i = 0; i < 6; i++) do_txn(tv[i], tv[i].lat + 1);

`ifdef ACCEL_WB_MASTER_TIMEOUT_EN
    // timeout, then a late ack that must be ignored
    sl_lat = 0; sl_ack = 1'b0; sl_err = 1'b0;
    cmd_we = 1'b0; cmd_addr = 32'h6000_0000; cmd_wdata = '0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    n = 0;
    while (wishbone_cyc_o && n < 40) begin n++; @(posedge clk); #1; end
    chk("to_stb_cycles", 32'(n), 32'(TO_CYC));
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rsp_rdata", rsp_rdata, 32'd0);
    force_ack = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    force_ack = 1'b0;
    chk("to_late_valid", 32'(rsp_valid), 32'd1);
    chk("to_late_err", 32'(rsp_err), 32'd1);
    chk("to_late_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("to_after_valid", 32'(rsp_valid), 32'd0);
    chk("to_after_busy", 32'(busy), 32'd0);
    sl_ack = 1'b1;
`endif

    // reset during REQ
    sl_stall = 1'b1;
    cmd_we = 1'b1; cmd_addr = 32'h7000_0000; cmd_wdata = 32'h0BAD_F00D; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("rreq_cyc_before", 32'(wishbone_cyc_o), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("rreq_cyc_async", 32'(wishbone_cyc_o), 32'd0);
    chk("rreq_stb_async", 32'(wishbone_stb_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    sl_stall = 1'b0;
    chk("rreq_busy", 32'(busy), 32'd0);
    chk("rreq_cmd_ready", 32'(cmd_ready), 32'd1);
    bad = 0;
    rsp_ready = 1'b1;
    repeat (5) begin
      if (rsp_valid || wishbone_cyc_o) bad++;
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    chk("rreq_no_response", 32'(bad), 32'd0);

    // FIFO fill with the bus stalled: 4 queued + 1 in REQ
    rand_mode = 1'b1;
    sl_stall = 1'b1;
    exp_q.delete();
    rsp_seen = 0;
    for (int i = 0; i < 5; i++) begin
      c.we = 1'(i % 2);
      c.addr = 32'h1000_0000 + 32'(i) * 32'h10;
      c.wdata = 32'hA000_0000 + 32'(i);
      chk("fill_ready", 32'(cmd_ready), 32'd1);
      run_cycle(1'b1, 1'b0, c);
    end
    chk("fill_full_ready", 32'(cmd_ready), 32'd0);
    chk("fill_busy", 32'(busy), 32'd1);
    c.we = 1'b0; c.addr = 32'h1000_0100; c.wdata = '0;
    run_cycle(1'b1, 1'b0, c);
    chk("fill_still_full", 32'(cmd_ready), 32'd0);
    sl_stall = 1'b0;
    cyc_cnt = 0;
    while (exp_q.size() != 0 && cyc_cnt < 300) begin
      run_cycle(1'b0, 1'b1, c);
      cyc_cnt++;
    end
    chk("fill_rsp_count", 32'(rsp_seen), 32'd5);
    chk("fill_drained", 32'(exp_q.size()), 32'd0);

    // randomized traffic against the queue model
    rsp_seen = 0;
    sent = 0;
    cyc_cnt = 0;
    while ((sent < N_RAND || exp_q.size() != 0) && cyc_cnt < 6000) begin
      c.we = 1'($urandom % 2);
      c.addr = $urandom;
      c.wdata = $urandom;
      off = (sent < N_RAND) && ($urandom % 10 < 7);
      if (off && cmd_ready) sent++;
      run_cycle(off, 1'($urandom % 10 < 6), c);
      cyc_cnt++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("rand_rsp_count", 32'(rsp_seen), 32'(N_RAND));
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    chk("rand_idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
